// File: rtl/branch_sequencer_pkg.sv
// Shared types and constants for the conditional-branch control sequencer.
package branch_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7,
    S_DONE
  } state_t;

  // C2 field: branch condition select
  localparam logic [1:0] C2_EQZ = 2'b00;
  localparam logic [1:0] C2_NEZ = 2'b01;
  localparam logic [1:0] C2_PL  = 2'b10;
  localparam logic [1:0] C2_MI  = 2'b11;

  localparam logic [4:0] ALU_NOP = 5'b00000;
  localparam logic [4:0] ALU_ADD = 5'b00011;

  localparam logic [4:0] BR_OPCODE_DEF = 5'b10010;
  localparam logic [4:0] ADD_OP_DEF    = ALU_ADD;

  // Instruction field positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int C2_MSB  = 20;
  localparam int C2_LSB  = 19;

endpackage

// File: rtl/branch_sequencer_con_eval.sv
// Branch condition evaluator: tests the bus value against the C2-selected condition.
module con_eval
  import branch_sequencer_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] bus_data,
  input  logic [1:0]        C2,
  output logic              cond
);

  always_comb begin
    cond = 1'b0;
    case (C2)
      C2_EQZ:  cond = (bus_data == '0);
      C2_NEZ:  cond = (bus_data != '0);
      C2_PL:   cond = ~bus_data[DATA_W-1];
      C2_MI:   cond = bus_data[DATA_W-1];
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Control sequencer for the conditional-branch family: fetch, memory wait with
// timeout, condition latch and PC+C update, all strobes decoded from state.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int         DATA_W    = 32,
  parameter logic [4:0] BR_OPCODE = BR_OPCODE_DEF,
  parameter logic [4:0] ADD_OP    = ADD_OP_DEF,
  parameter int         WAIT_MAX  = 15
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [DATA_W-1:0] IR,
  input  logic [DATA_W-1:0] bus_data,
  input  logic              Mem_ready,
  output logic              PCout,
  output logic              PCin,
  output logic              MARin,
  output logic              MDRin,
  output logic              MDRout,
  output logic              IRin,
  output logic              IncPC,
  output logic              Read,
  output logic              Yin,
  output logic              Zin,
  output logic              Zlowout,
  output logic              Cout,
  output logic              Rout,
  output logic              GRA,
  output logic              CON_in,
  output logic [4:0]        operation,
  output logic              Branch_taken,
  output logic              Done,
  output logic              Illegal,
  output logic              Bus_error
);

  localparam int              WAIT_W    = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic              r_branch_taken;
  logic              r_illegal;
  logic              r_bus_error;
  logic              w_cond;
  logic              w_opc_ok;
  logic              w_timeout;
  logic              w_unused_ir;

  con_eval #(
    .DATA_W(DATA_W)
  ) u_con_eval (
    .bus_data(bus_data),
    .C2      (IR[C2_MSB:C2_LSB]),
    .cond    (w_cond)
  );

  assign w_opc_ok    = (IR[OPC_MSB:OPC_LSB] == BR_OPCODE);
  assign w_timeout   = (r_state == S_T2) && !Mem_ready && (r_wait == WAIT_LAST);
  assign w_unused_ir = ^IR;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_next = S_T0;
      S_T0:    w_next = S_T1;
      S_T1:    w_next = S_T2;
      S_T2: begin
        if (Mem_ready)      w_next = S_T3;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_T3:    w_next = S_T4;
      S_T4:    w_next = w_opc_ok ? S_T5 : S_DONE;
      S_T5:    w_next = S_T6;
      S_T6:    w_next = S_T7;
      S_T7:    w_next = S_DONE;
      S_DONE:  w_next = Start ? S_T0 : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Wait counter is held at zero outside T2, so every T2 entry starts from 0.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wait         <= '0;
      r_branch_taken <= 1'b0;
      r_illegal      <= 1'b0;
      r_bus_error    <= 1'b0;
    end else begin
      r_bus_error <= w_timeout;
      if ((r_state == S_T2) && !Mem_ready) begin
        r_wait <= r_wait + 1'b1;
      end else begin
        r_wait <= '0;
      end
      if (r_state == S_T0) begin
        r_branch_taken <= 1'b0;
        r_illegal      <= 1'b0;
      end else if (r_state == S_T4) begin
        if (w_opc_ok) r_branch_taken <= w_cond;
        else          r_illegal      <= 1'b1;
      end
    end
  end

  always_comb begin
    PCout     = 1'b0;
    PCin      = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    IRin      = 1'b0;
    IncPC     = 1'b0;
    Read      = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    Zlowout   = 1'b0;
    Cout      = 1'b0;
    Rout      = 1'b0;
    GRA       = 1'b0;
    CON_in    = 1'b0;
    operation = ALU_NOP;
    Done      = 1'b0;
    Illegal   = 1'b0;
    case (r_state)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
      end
      S_T2: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      S_T3: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T4: begin
        Rout   = 1'b1;
        GRA    = 1'b1;
        CON_in = 1'b1;
      end
      S_T5: begin
        PCout = 1'b1;
        Yin   = 1'b1;
      end
      S_T6: begin
        Cout      = 1'b1;
        Zin       = 1'b1;
        operation = ADD_OP;
      end
      S_T7: begin
        Zlowout = r_branch_taken;
        PCin    = r_branch_taken;
      end
      S_DONE: begin
        Done    = 1'b1;
        Illegal = r_illegal;
      end
      default: ;
    endcase
  end

  assign Branch_taken = r_branch_taken;
  assign Bus_error    = r_bus_error;

endmodule

// File: tb/tb_branch_sequencer.sv
// Randomised and directed bench for branch_sequencer against an instruction-level model.
module tb_branch_sequencer;

  localparam int         DATA_W   = 32;
  localparam int         WAIT_MAX = 15;
  localparam logic [4:0] BR_OP    = 5'b10010;
  localparam logic [4:0] ADD_OP   = 5'b00011;

  logic        Clock;
  logic        Reset_n;
  logic        Start;
  logic [31:0] IR;
  logic [31:0] bus_data;
  logic        Mem_ready;
  logic PCout, PCin, MARin, MDRin, MDRout, IRin, IncPC, Read;
  logic Yin, Zin, Zlowout, Cout, Rout, GRA, CON_in;
  logic [4:0] operation;
  logic Branch_taken, Done, Illegal, Bus_error;

  logic [14:0] strobes;
  logic [23:0] all_out;
  assign strobes = {PCout, PCin, MARin, MDRin, MDRout, IRin, IncPC, Read,
                    Yin, Zin, Zlowout, Cout, Rout, GRA, CON_in};
  assign all_out = {strobes, operation, Branch_taken, Done, Illegal, Bus_error};

  int n_checks = 0;
  int n_pass   = 0;

  branch_sequencer #(
    .DATA_W   (DATA_W),
    .BR_OPCODE(BR_OP),
    .ADD_OP   (ADD_OP),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .Start       (Start),
    .IR          (IR),
    .bus_data    (bus_data),
    .Mem_ready   (Mem_ready),
    .PCout       (PCout),
    .PCin        (PCin),
    .MARin       (MARin),
    .MDRin       (MDRin),
    .MDRout      (MDRout),
    .IRin        (IRin),
    .IncPC       (IncPC),
    .Read        (Read),
    .Yin         (Yin),
    .Zin         (Zin),
    .Zlowout     (Zlowout),
    .Cout        (Cout),
    .Rout        (Rout),
    .GRA         (GRA),
    .CON_in      (CON_in),
    .operation   (operation),
    .Branch_taken(Branch_taken),
    .Done        (Done),
    .Illegal     (Illegal),
    .Bus_error   (Bus_error)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic ref_cond(input logic [31:0] bus, input logic [1:0] c2);
    case (c2)
      2'b00:   return bus == 32'd0;
      2'b01:   return bus != 32'd0;
      2'b10:   return bus[31] == 1'b0;
      default: return bus[31] == 1'b1;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // One instruction from IDLE; Mem_ready is withheld for `waits` T2 cycles.
  task automatic run_instr(input logic [31:0] ir, input logic [31:0] bus, input int waits,
                           input bit noise, input string tag);
    int  t0_n, done_n, berr_n, pcin_cnt, yin_cnt, read_cnt, op_cnt, op_bad, ill_stray;
    logic ill_at_done, bt_at_done;
    bit  exp_legal, exp_taken, exp_err;
    int  exp_lat;
    exp_legal = (ir[31:27] == BR_OP);
    exp_taken = exp_legal && ref_cond(bus, ir[20:19]);
    exp_err   = (waits >= WAIT_MAX);
    exp_lat   = (exp_legal ? 9 : 6) + waits;
    t0_n = -1; done_n = -1; berr_n = -1;
    pcin_cnt = 0; yin_cnt = 0; read_cnt = 0; op_cnt = 0; op_bad = 0; ill_stray = 0;
    ill_at_done = 1'b0; bt_at_done = 1'b0;
    IR = ir; bus_data = bus; Mem_ready = 1'b0; Start = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge Clock); #1;
      Start = noise && (n >= 2) && (n <= 4);
      if (PCout && MARin && IncPC && Zin && t0_n < 0) t0_n = n;
      if (Read) begin
        read_cnt++;
        Mem_ready = (read_cnt > waits);
      end else begin
        Mem_ready = 1'b0;
      end
      if (PCin) pcin_cnt++;
      if (Yin) yin_cnt++;
      if (operation != 5'd0) begin
        op_cnt++;
        if (!Cout || operation !== ADD_OP) op_bad++;
      end
      if (Illegal && !Done) ill_stray++;
      if (Done) begin
        done_n = n; ill_at_done = Illegal; bt_at_done = Branch_taken;
        break;
      end
      if (Bus_error) begin
        berr_n = n;
        break;
      end
    end
    Start = 1'b0;
    Mem_ready = 1'b0;
    check({tag, " t0_after_start"}, t0_n, 1);
    check({tag, " t2_cycles"}, read_cnt, exp_err ? WAIT_MAX : waits + 1);
    check({tag, " illegal_stray"}, ill_stray, 0);
    if (exp_err) begin
      check({tag, " bus_error_seen"}, berr_n > 0, 1);
      check({tag, " no_done"}, done_n, -1);
      @(posedge Clock); #1;
      check({tag, " bus_error_one_cycle"}, Bus_error, 0);
      check({tag, " idle_after_error"}, strobes, 0);
    end else begin
      check({tag, " latency"}, done_n - t0_n + 1, exp_lat);
      check({tag, " illegal"}, ill_at_done, !exp_legal);
      check({tag, " branch_taken"}, bt_at_done, exp_taken);
      check({tag, " pcin_count"}, pcin_cnt, 1 + int'(exp_taken));
      check({tag, " yin_count"}, yin_cnt, int'(exp_legal));
      check({tag, " add_op_cycles"}, op_cnt, int'(exp_legal));
      check({tag, " op_only_with_cout"}, op_bad, 0);
      @(posedge Clock); #1;
      check({tag, " taken_held"}, Branch_taken, exp_taken);
      check({tag, " idle_after_done"}, {strobes, Done}, 0);
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; Start = 1'b1; IR = 32'h9080_0000; bus_data = '0; Mem_ready = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    check("reset_outputs", all_out, 0);
    #3;
    check("reset_outputs_between_edges", all_out, 0);
    @(posedge Clock); #1;
    Start = 1'b0; Mem_ready = 1'b0;
    Reset_n = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    check("idle_without_start", all_out, 0);
  endtask

  task automatic test_branches();
    run_instr(32'h9080_0000, 32'h0000_0000, 0, 1'b0, "brzr_taken");
    run_instr(32'h9088_0000, 32'h0000_0000, 0, 1'b0, "brnz_not_taken");
    run_instr(32'h9090_0000, 32'h8000_0000, 0, 1'b0, "brpl_not_taken");
    run_instr(32'h9098_0000, 32'h8000_0000, 0, 1'b0, "brmi_taken");
  endtask

  task automatic test_mem_wait();
    run_instr(32'h9080_0000, 32'h0000_0000, 3, 1'b0, "wait3");
    run_instr(32'h9088_0000, 32'h0000_0010, WAIT_MAX - 1, 1'b0, "wait_max_minus_1");
    run_instr(32'h9080_0000, 32'h0000_0000, WAIT_MAX, 1'b0, "wait_timeout");
  endtask

  task automatic test_illegal();
    run_instr(32'h1880_0000, 32'h0000_0000, 0, 1'b0, "illegal_op");
  endtask

  task automatic test_reset_mid();
    bit seen_cout;
    bit stray;
    seen_cout = 1'b0;
    IR = 32'h9080_0000; bus_data = '0; Start = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(posedge Clock); #1;
      Start = 1'b0;
      Mem_ready = Read;
      if (Cout) begin
        seen_cout = 1'b1;
        break;
      end
    end
    check("mid_reset_reached_t6", seen_cout, 1);
    #2 Reset_n = 1'b0;
    #1;
    check("mid_reset_async_outputs", all_out, 0);
    @(posedge Clock); #1;
    check("mid_reset_held_outputs", all_out, 0);
    Reset_n = 1'b1; Mem_ready = 1'b0;
    stray = 1'b0;
    repeat (4) begin
      @(posedge Clock); #1;
      if (all_out != 0) stray = 1'b1;
    end
    check("mid_reset_stays_idle", stray, 0);
  endtask

  task automatic test_back_to_back();
    int t0a, done1, t0b, done2;
    t0a = -1; done1 = -1; t0b = -1; done2 = -1;
    IR = 32'h9080_0000; bus_data = '0; Mem_ready = 1'b0; Start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge Clock); #1;
      Mem_ready = Read;
      if (PCout && MARin && IncPC && Zin) begin
        if (t0a < 0) t0a = n;
        else if (done1 >= 0 && t0b < 0) t0b = n;
      end
      if (Done) begin
        if (done1 < 0) done1 = n;
        else begin
          done2 = n;
          Start = 1'b0;
          break;
        end
      end
    end
    Start = 1'b0; Mem_ready = 1'b0;
    check("b2b_first_latency", done1 - t0a + 1, 9);
    check("b2b_done_to_t0", t0b, done1 + 1);
    check("b2b_second_latency", done2 - t0b + 1, 9);
    check("b2b_taken", Branch_taken, 1);
    @(posedge Clock); #1;
    check("b2b_idle_after", {strobes, Done}, 0);
  endtask

  task automatic test_random();
    logic [31:0] r, ir, bus;
    logic [4:0]  op;
    int          waits, sel;
    bit          noise;
    for (int i = 0; i < 30; i++) begin
      r  = $urandom();
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom()) : BR_OP;
      ir = {op, r[26:0]};
      r  = $urandom();
      sel = $urandom_range(0, 3);
      case (sel)
        0:       bus = 32'd0;
        1:       bus = r | 32'h8000_0000;
        2:       bus = r & 32'h7fff_ffff;
        default: bus = r;
      endcase
      sel = $urandom_range(0, 9);
      if (sel < 6)      waits = $urandom_range(0, 3);
      else if (sel < 8) waits = WAIT_MAX - 1;
      else if (sel < 9) waits = WAIT_MAX;
      else              waits = $urandom_range(4, 8);
      noise = 1'($urandom_range(0, 1));
      run_instr(ir, bus, waits, noise, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    Reset_n = 1'b0; Start = 1'b0; IR = '0; bus_data = '0; Mem_ready = 1'b0;
    test_reset();
    test_branches();
    test_mem_wait();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Parameter DATA_W, default 32: bus and IR width; SHALL be at least 32.
REQ-002 Parameter BR_OPCODE, default 5'b10010: IR[31:27] value identifying the conditional-branch family.
REQ-003 Parameter ADD_OP, default 5'b00011: ALU operation code driven on `operation` for the PC+C add.
REQ-004 Parameter WAIT_MAX, default 15: maximum wait cycles for Mem_ready before abort.
REQ-005 Clock  input  1  single clock; all state changes on the rising edge.
REQ-006 Reset_n  input  1  asynchronous, active-low reset.
REQ-007 Start  input  1  request to fetch and execute one instruction.
REQ-008 IR  input  DATA_W  current instruction register contents.
REQ-009 bus_data  input  DATA_W  datapath bus, sampled for condition evaluation.
REQ-010 Mem_ready  input  1  memory read-complete handshake.
REQ-011 PCout, PCin, MARin, MDRin, MDRout, IRin, IncPC, Read, Yin, Zin, Zlowout, Cout, Rout, GRA, CON_in  output  1 each  datapath control strobes.
REQ-012 operation  output  5  ALU operation select; ADD_OP in T6, otherwise 0.
REQ-013 Branch_taken  output  1  latched condition result for the current instruction.
REQ-014 Done  output  1  one-cycle pulse when the instruction completes.
REQ-015 Illegal  output  1  one-cycle pulse, asserted with Done, when the opcode is not BR_OPCODE.
REQ-016 Bus_error  output  1  one-cycle pulse on Mem_ready timeout.

Function
REQ-017 The FSM SHALL have states IDLE, T0, T1, T2, T3, T4, T5, T6, T7, DONE, and all strobes SHALL be Moore outputs decoded from state only.
REQ-018 IDLE: all strobes are 0; the FSM goes to T0 when Start=1.
REQ-019 T0: PCout, MARin, IncPC and Zin are 1; Branch_taken clears to 0; next state is T1.
REQ-020 T1: Zlowout and PCin are 1; next state is T2.
REQ-021 T2: Read and MDRin are 1. The FSM stays in T2 while Mem_ready=0 and moves to T3 on the first cycle with Mem_ready=1.
REQ-022 The wait counter resets to 0 on entry to T2 and increments each T2 cycle with Mem_ready=0. If it reaches WAIT_MAX with Mem_ready still 0, Bus_error pulses and the FSM returns to IDLE.
REQ-023 T3: MDRout and IRin are 1; next state is T4.
REQ-024 T4: Rout, GRA and CON_in are 1. The condition flag latches from bus_data using C2=IR[20:19]:
- 00: bus==0
- 01: bus!=0
- 10: bus[DATA_W-1]==0
- 11: bus[DATA_W-1]==1
REQ-025 In T4, if IR[31:27]!=BR_OPCODE, the flag SHALL NOT latch and the FSM goes to DONE with Illegal=1; otherwise the next state is T5.
REQ-026 T5: PCout and Yin are 1; next state is T6.
REQ-027 T6: Cout and Zin are 1 and operation=ADD_OP; next state is T7.
REQ-028 T7: Zlowout and PCin are 1 only if Branch_taken=1, otherwise all strobes are 0; next state is DONE.
REQ-029 DONE: Done=1 for exactly one cycle; the FSM goes to T0 if Start=1, else to IDLE (back-to-back execution).
REQ-030 Start is ignored outside IDLE and DONE.
REQ-031 Branch_taken SHALL hold its value from T4 until the next T0.
REQ-032 Latency from T0 to the Done pulse SHALL be 9 cycles plus the number of Mem_ready wait cycles.
REQ-033 If Mem_ready is already 1 on entry to T2, T2 SHALL last exactly one cycle.

Reset
REQ-034 While Reset_n=0: state is IDLE, all strobes are 0, operation=0, Branch_taken, Done, Illegal and Bus_error are 0, and the wait counter is 0. This applies immediately, independent of Clock.
REQ-035 Reset asserted mid-instruction SHALL abort it with no further strobes. After release, the FSM SHALL wait for Start in IDLE.

Structure
REQ-036 A shared package SHALL hold:
- the state enumeration,
- C2 encodings,
- the BR_OPCODE and ADD_OP defaults,
- the ALU opcode constants.
REQ-037 Condition evaluation SHALL be a separate combinational sub-module, con_eval (inputs bus_data and C2; output cond).
REQ-038 The FSM, wait counter and Branch_taken flop SHALL reside in branch_sequencer.

Verification
REQ-039 brzr taken: IR=32'h9080_0000 (opcode 10010, C2=00), bus=0, Mem_ready=1 immediately -> Branch_taken=1, Zlowout and PCin asserted in T7, Done 9 cycles after T0.
REQ-040 brnz not taken: C2=01, bus=0 -> Branch_taken=0, no PCin in T7, Done still pulses.
REQ-041 brpl/brmi: bus=32'h8000_0000 -> C2=10 gives Branch_taken=0 and C2=11 gives Branch_taken=1.
REQ-042 Memory wait: Mem_ready held low 3 cycles -> T2 lasts 4 cycles and Done arrives at T0+12. Held low for WAIT_MAX cycles -> Bus_error pulses and the FSM returns to IDLE.
REQ-043 Illegal opcode: IR[31:27]=5'b00011 -> Done and Illegal pulse together at T0+6, and no T5-T7 strobes occur.
REQ-044 Reset mid-T6 -> all outputs are 0 asynchronously and the FSM is in IDLE. With Start held high and no reset, two back-to-back instructions run with DONE going directly to T0.
